pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard unit: load-use stall, branch flush, operand forwarding
// Optional macro PIPE_HAZARD_PERF_EN adds saturating StallCount/FlushCount outputs.
module pipe_hazard_ctrl #(
  parameter int FWD_DEPTH      = 2,
  parameter int LOAD_READY     = 2,
  parameter int REG_ADDR_WIDTH = 5,
  localparam int FW            = $clog2(FWD_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] RdD,
  input  logic                      RegWriteD,
  input  logic                      LoadD,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
  input  logic                      PCSrcE,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic [FW-1:0]             ForwardAE,
  output logic [FW-1:0]             ForwardBE
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0]               StallCount,
  output logic [31:0]               FlushCount
`endif
);

  // Shadow copy of the destination info travelling down E, M, W, ...
  logic [REG_ADDR_WIDTH-1:0] rdQ       [0:FWD_DEPTH];
  logic                      regWriteQ [0:FWD_DEPTH];
  logic                      loadQ     [0:FWD_DEPTH];

  logic          lwStall;
  logic [FW-1:0] fwdA;
  logic [FW-1:0] fwdB;

  // Advance the shadow pipeline; position 0 takes a bubble whenever D/E is flushed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k <= FWD_DEPTH; k++) begin
        rdQ[k]       <= '0;
        regWriteQ[k] <= 1'b0;
        loadQ[k]     <= 1'b0;
      end
    end else begin
      for (int k = FWD_DEPTH; k >= 1; k--) begin
        rdQ[k]       <= rdQ[k-1];
        regWriteQ[k] <= regWriteQ[k-1];
        loadQ[k]     <= loadQ[k-1];
      end
      if (FlushE) begin
        rdQ[0]       <= '0;
        regWriteQ[0] <= 1'b0;
        loadQ[0]     <= 1'b0;
      end else begin
        rdQ[0]       <= RdD;
        regWriteQ[0] <= RegWriteD;
        loadQ[0]     <= LoadD;
      end
    end
  end

  // Stall while a load whose data is not yet forwardable feeds the decode instruction
  always_comb begin
    lwStall = 1'b0;
    for (int p = 0; p < LOAD_READY - 1; p++) begin
      if (loadQ[p] && regWriteQ[p] && (rdQ[p] != '0) &&
          ((rdQ[p] == Rs1D) || (rdQ[p] == Rs2D)))
        lwStall = 1'b1;
    end
  end

  // Pick the youngest producer: scan oldest to newest so the nearest match wins
  always_comb begin
    fwdA = '0;
    fwdB = '0;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (regWriteQ[k] && (rdQ[k] != '0) && (rdQ[k] == Rs1E))
        fwdA = FW'(k);
      if (regWriteQ[k] && (rdQ[k] != '0) && (rdQ[k] == Rs2E))
        fwdB = FW'(k);
    end
  end

  // A taken branch overrides the stall so the redirect PC is captured
  assign StallF    = ~reset & lwStall & ~PCSrcE;
  assign StallD    = ~reset & lwStall & ~PCSrcE;
  assign FlushD    = ~reset & PCSrcE;
  assign FlushE    = ~reset & (lwStall | PCSrcE);
  assign ForwardAE = reset ? '0 : fwdA;
  assign ForwardBE = reset ? '0 : fwdB;

`ifdef PIPE_HAZARD_PERF_EN
  // Saturating counts of stalled and flushed decode cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (StallD && (StallCount != 32'hFFFF_FFFF))
        StallCount <= StallCount + 32'd1;
      if (FlushD && (FlushCount != 32'hFFFF_FFFF))
        FlushCount <= FlushCount + 32'd1;
    end
  end
`endif

endmodule
